ifetch_unit: RTL and testbench

Instruction fetch front end; the requesting side of the instruction-memory read port. Owns the PC, drives the word address to instruction memory (combinational read, data valid same cycle), and buffers fetched {pc, instr} pairs in a small prefetch FIFO. Hands them to decode over a valid/ready handshake. Supports branch/jump redirect with full flush.

---
 rtl/ifetch_unit_if.sv | 28 ++
 rtl/ifetch_unit.sv | 87 ++++++++
 tb/tb_ifetch_unit.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/ifetch_unit_if.sv
// Instruction-fetch bus bundle: instruction-memory read port plus the
// {pc, instr} valid/ready handshake towards decode.
interface ifetch_unit_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rd;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  modport master (
    output imem_addr,
    input  imem_rd,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc
  );

  modport slave (
    input  imem_addr,
    output imem_rd,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: owns the PC, reads instruction memory and
// buffers {pc, instr} pairs in a prefetch FIFO drained by decode.
module ifetch_unit #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     fetch_en,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  ifetch_unit_if.master            bus,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]      pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

  logic [31:0] buf_pc_q    [DEPTH];
  logic [31:0] buf_instr_q [DEPTH];

  logic out_valid;
  logic pop;
  logic push;

  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid & bus.out_ready;
  // A full FIFO still accepts a fetch when the head leaves in the same cycle.
  assign push      = fetch_en & ~redirect & ((cnt_q < CNT_W'(DEPTH)) | pop);

  always_comb begin
    pc_d     = pc_q;
    cnt_d    = cnt_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (redirect) begin
      pc_d     = {redirect_pc[31:2], 2'b00};
      cnt_d    = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) begin
        pc_d     = pc_q + 32'd4;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      cnt_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Storage is deliberately left unreset; stale contents are masked by out_valid.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      buf_pc_q[wr_ptr_q]    <= pc_q;
      buf_instr_q[wr_ptr_q] <= bus.imem_rd;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.out_valid = out_valid;
  assign bus.out_instr = out_valid ? buf_instr_q[rd_ptr_q] : NOP;
  assign bus.out_pc    = out_valid ? buf_pc_q[rd_ptr_q] : 32'h0;
  assign fifo_count    = cnt_q;

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed vector table plus a
// randomized phase, both checked against a queue-based scoreboard.
module tb_ifetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        fetch_en;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [2:0]  fifo_count;

  ifetch_unit_if bus ();

  ifetch_unit #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_en    (fetch_en),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus),
    .fifo_count  (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] imem(input logic [31:0] addr);
    logic [29:0] idx;
    idx = addr[31:2];
    case (idx)
      30'd0:   return 32'h0010_0093;
      30'd1:   return 32'h0010_0113;
      30'd2:   return 32'h0020_81B3;
      30'd3:   return 32'h0031_0233;
      30'd4:   return 32'h0041_82B3;
      30'd5:   return 32'h0052_0333;
      30'd6:   return 32'h0062_83B3;
      30'd7:   return 32'h0000_0013;
      30'd8:   return 32'h0000_0013;
      default: return 32'hDEAD_0000 | {16'h0, addr[15:0]};
    endcase
  endfunction

  assign bus.imem_rd = imem(bus.imem_addr);

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  typedef struct {
    logic        rst;
    logic        fe;
    logic        rdr;
    logic [31:0] rpc;
    logic        ordy;
    logic        chk;
    logic [2:0]  cnt;
    logic        vld;
    logic [31:0] addr;
    logic [31:0] opc;
    logic [31:0] oinstr;
  } vec_t;

  int n_pass = 0;
  int n_tot  = 0;

  entry_t      sb[$];
  logic [31:0] m_pc;
  bit          m_known = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Applies one cycle of inputs, checks outputs against the scoreboard model,
  // advances the model, then steps past the next rising edge.
  task automatic cycle(input logic rst, input logic fe, input logic rdr,
                       input logic [31:0] rpc, input logic ordy);
    int     size0;
    bit     popped;
    entry_t e;
    reset       = rst;
    fetch_en    = fe;
    redirect    = rdr;
    redirect_pc = rpc;
    bus.out_ready = ordy;
    #2;
    popped = 1'b0;
    size0  = sb.size();
    if (m_known) begin
      check("sb_imem_addr", bus.imem_addr, m_pc);
      check("sb_fifo_count", {29'h0, fifo_count}, size0);
      check("sb_out_valid", {31'h0, bus.out_valid}, {31'h0, size0 != 0});
      if (size0 == 0) begin
        check("sb_idle_instr", bus.out_instr, NOP);
        check("sb_idle_pc", bus.out_pc, 32'h0);
      end else begin
        e = sb[0];
        check("sb_head_pc", bus.out_pc, e.pc);
        check("sb_head_instr", bus.out_instr, e.instr);
        if (ordy && !rst) begin
          void'(sb.pop_front());
          popped = 1'b1;
        end
      end
    end
    if (rst) begin
      sb.delete();
      m_pc    = 32'h0;
      m_known = 1'b1;
    end else if (m_known) begin
      if (rdr) begin
        sb.delete();
        m_pc = {rpc[31:2], 2'b00};
      end else if (fe && (size0 < 4 || popped)) begin
        e.pc    = m_pc;
        e.instr = imem(m_pc);
        sb.push_back(e);
        m_pc = m_pc + 32'd4;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic rst, input logic fe, input logic rdr,
                              input logic [31:0] rpc, input logic ordy, input logic chk,
                              input logic [2:0] cnt, input logic vld, input logic [31:0] addr,
                              input logic [31:0] opc, input logic [31:0] oinstr);
    vec_t v;
    v.rst = rst; v.fe = fe; v.rdr = rdr; v.rpc = rpc; v.ordy = ordy; v.chk = chk;
    v.cnt = cnt; v.vld = vld; v.addr = addr; v.opc = opc; v.oinstr = oinstr;
    return v;
  endfunction

  initial begin
    vec_t vecs[$];

    reset = 1'b1; fetch_en = 1'b0; redirect = 1'b0; redirect_pc = '0; bus.out_ready = 1'b0;

    // rst fe rdr rpc ordy | chk cnt vld addr opc instr  (outputs seen before the edge)
    vecs.push_back(mk(1,0,0,32'h0,0, 0,0,0,32'h00,32'h00,NOP));
    vecs.push_back(mk(1,0,0,32'h0,0, 1,0,0,32'h00,32'h00,NOP));
    // back-pressure: fill to 4 and hold at 0x10
    vecs.push_back(mk(0,1,0,32'h0,0, 1,0,0,32'h00,32'h00,NOP));
    vecs.push_back(mk(0,1,0,32'h0,0, 1,1,1,32'h04,32'h00,32'h0010_0093));
    vecs.push_back(mk(0,1,0,32'h0,0, 1,2,1,32'h08,32'h00,32'h0010_0093));
    vecs.push_back(mk(0,1,0,32'h0,0, 1,3,1,32'h0C,32'h00,32'h0010_0093));
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(0,1,0,32'h0,0, 1,4,1,32'h10,32'h00,32'h0010_0093));
    // drain with simultaneous refill: count stays 4, one push per cycle
    vecs.push_back(mk(0,1,0,32'h0,1, 1,4,1,32'h10,32'h00,32'h0010_0093));
    vecs.push_back(mk(0,1,0,32'h0,1, 1,4,1,32'h14,32'h04,32'h0010_0113));
    vecs.push_back(mk(0,1,0,32'h0,1, 1,4,1,32'h18,32'h08,32'h0020_81B3));
    vecs.push_back(mk(0,1,0,32'h0,1, 1,4,1,32'h1C,32'h0C,32'h0031_0233));
    vecs.push_back(mk(0,1,0,32'h0,1, 1,4,1,32'h20,32'h10,32'h0041_82B3));
    vecs.push_back(mk(0,1,0,32'h0,1, 1,4,1,32'h24,32'h14,32'h0052_0333));
    // redirect to 0x18 while full and stalled
    vecs.push_back(mk(0,1,1,32'h18,0, 1,4,1,32'h28,32'h18,32'h0062_83B3));
    vecs.push_back(mk(0,1,0,32'h0,0, 1,0,0,32'h18,32'h00,NOP));
    // redirect to unaligned 0xE while head 0x18 is popped
    vecs.push_back(mk(0,1,1,32'hE,1, 1,1,1,32'h1C,32'h18,32'h0062_83B3));
    vecs.push_back(mk(0,1,0,32'h0,1, 1,0,0,32'h0C,32'h00,NOP));
    vecs.push_back(mk(0,1,0,32'h0,1, 1,1,1,32'h10,32'h0C,32'h0031_0233));
    vecs.push_back(mk(0,1,0,32'h0,0, 1,1,1,32'h14,32'h10,32'h0041_82B3));
    vecs.push_back(mk(0,1,0,32'h0,0, 1,2,1,32'h18,32'h10,32'h0041_82B3));
    // reset mid-stream with 3 entries
    vecs.push_back(mk(1,1,0,32'h0,1, 1,3,1,32'h1C,32'h10,32'h0041_82B3));
    vecs.push_back(mk(0,1,0,32'h0,1, 1,0,0,32'h00,32'h00,NOP));
    vecs.push_back(mk(0,1,0,32'h0,1, 1,1,1,32'h04,32'h00,32'h0010_0093));
    vecs.push_back(mk(0,1,0,32'h0,0, 1,1,1,32'h08,32'h04,32'h0010_0113));
    // fetch_en=0: two entries drain, PC frozen
    vecs.push_back(mk(0,0,0,32'h0,1, 1,2,1,32'h0C,32'h04,32'h0010_0113));
    vecs.push_back(mk(0,0,0,32'h0,1, 1,1,1,32'h0C,32'h08,32'h0020_81B3));
    vecs.push_back(mk(0,0,0,32'h0,1, 1,0,0,32'h0C,32'h00,NOP));
    vecs.push_back(mk(0,0,0,32'h0,1, 1,0,0,32'h0C,32'h00,NOP));
    // redirect still honoured with fetch_en=0; then PC wrap-around
    vecs.push_back(mk(0,0,1,32'hFFFF_FFFC,1, 1,0,0,32'h0C,32'h00,NOP));
    vecs.push_back(mk(0,1,0,32'h0,1, 1,0,0,32'hFFFF_FFFC,32'h00,NOP));
    vecs.push_back(mk(0,1,0,32'h0,1, 1,1,1,32'h00,32'hFFFF_FFFC,32'hDEAD_FFFC));
    vecs.push_back(mk(0,1,0,32'h0,1, 1,1,1,32'h04,32'h00,32'h0010_0093));

    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      reset = vecs[i].rst; fetch_en = vecs[i].fe; redirect = vecs[i].rdr;
      redirect_pc = vecs[i].rpc; bus.out_ready = vecs[i].ordy;
      #1;
      if (vecs[i].chk) begin
        check($sformatf("v%0d_fifo_count", i), {29'h0, fifo_count}, {29'h0, vecs[i].cnt});
        check($sformatf("v%0d_out_valid", i), {31'h0, bus.out_valid}, {31'h0, vecs[i].vld});
        check($sformatf("v%0d_imem_addr", i), bus.imem_addr, vecs[i].addr);
        check($sformatf("v%0d_out_pc", i), bus.out_pc, vecs[i].opc);
        check($sformatf("v%0d_out_instr", i), bus.out_instr, vecs[i].oinstr);
      end
      cycle(vecs[i].rst, vecs[i].fe, vecs[i].rdr, vecs[i].rpc, vecs[i].ordy);
    end

    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 60) == 0, ($urandom % 5) != 0, ($urandom % 15) == 0,
            $urandom_range(0, 40), ($urandom % 3) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
